// File: rtl/sr_pkg.sv
// Shared types and defaults for the debounced SR latch controller.
// Holds the latch FSM state encoding and the default debounce length.
package sr_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    Q_RESET  = 2'b00,
    Q_SET    = 2'b01,
    CONFLICT = 2'b10
  } sr_state_t;

endpackage

// File: rtl/sr_debounce_chan.sv
// One button channel: 2-flop synchronizer, saturating debounce counter,
// stable level and a one-cycle pulse on its rising edge.
module sr_debounce_chan
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_lvl,
  output logic o_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_lvl;
  logic             r_lvl_d;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  logic w_diff;
  logic w_done;

  assign w_diff = r_sync[1] ^ r_lvl;
  assign w_done = w_diff && (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_lvl   <= 1'b0;
      r_lvl_d <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_lvl_d <= r_lvl;
      r_pulse <= r_lvl & ~r_lvl_d;
      // Any bounce back to the stable level restarts the count.
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt <= '0;
        r_lvl <= ~r_lvl;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_lvl   = r_lvl;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/sr_debounce_ctrl.sv
// Debounced set/reset buttons driving a registered NOR-style SR latch.
// Both levels high is reported as CONFLICT with q and notq both low.
module sr_debounce_ctrl
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic rst_btn,
  output logic s_pulse,
  output logic r_pulse,
  output logic q,
  output logic notq,
  output logic invalid
);

  logic w_s_lvl;
  logic w_r_lvl;

  sr_state_t r_state;
  sr_state_t w_next;

  logic r_q, r_notq, r_inv;
  logic w_q, w_notq, w_inv;

  sr_debounce_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_set (
    .clk(clk),
    .rst_n(rst_n),
    .i_raw(set_btn),
    .o_lvl(w_s_lvl),
    .o_pulse(s_pulse)
  );

  sr_debounce_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_rst (
    .clk(clk),
    .rst_n(rst_n),
    .i_raw(rst_btn),
    .o_lvl(w_r_lvl),
    .o_pulse(r_pulse)
  );

  // Outputs are registered from the next state so they move with the pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= Q_RESET;
      r_q     <= 1'b0;
      r_notq  <= 1'b1;
      r_inv   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_q     <= w_q;
      r_notq  <= w_notq;
      r_inv   <= w_inv;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (w_s_lvl & ~w_r_lvl): w_next = Q_SET;
      (~w_s_lvl & w_r_lvl): w_next = Q_RESET;
      (w_s_lvl & w_r_lvl):  w_next = CONFLICT;
      default: begin
        if (r_state == CONFLICT) w_next = Q_RESET;
      end
    endcase
  end

  always_comb begin
    w_q    = 1'b0;
    w_notq = 1'b1;
    w_inv  = 1'b0;
    unique case (w_next)
      Q_SET: begin
        w_q    = 1'b1;
        w_notq = 1'b0;
      end
      CONFLICT: begin
        w_notq = 1'b0;
        w_inv  = 1'b1;
      end
      default: begin
        w_q    = 1'b0;
        w_notq = 1'b1;
      end
    endcase
  end

  assign q       = r_q;
  assign notq    = r_notq;
  assign invalid = r_inv;

endmodule

// File: tb/tb_sr_debounce_ctrl.sv
// Bench for sr_debounce_ctrl with a 4-cycle debounce window.
// Cycle model feeds a queue of expected outputs; directed checks on top.
module tb_sr_debounce_ctrl;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic set_btn = 1'b0;
  logic rst_btn = 1'b0;
  logic s_pulse, r_pulse, q, notq, invalid;

  int checks = 0;
  int failures = 0;
  int sp_cnt = 0;
  int rp_cnt = 0;

  sr_debounce_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .set_btn(set_btn),
    .rst_btn(rst_btn),
    .s_pulse(s_pulse),
    .r_pulse(r_pulse),
    .q(q),
    .notq(notq),
    .invalid(invalid)
  );

  always #5 clk = ~clk;

  // Reference model: {q, notq, invalid, s_pulse, r_pulse}
  logic [4:0] exp_q[$];
  logic [1:0] ms_sync = 2'b00, mr_sync = 2'b00;
  logic ms_lvl = 1'b0, mr_lvl = 1'b0;
  logic ms_prev = 1'b0, mr_prev = 1'b0;
  logic ms_p = 1'b0, mr_p = 1'b0;
  int ms_run = 0, mr_run = 0;
  int mst = 0;

  function automatic logic [4:0] outv(int st, logic sp, logic rp);
    case (st)
      1: outv = {3'b100, sp, rp};
      2: outv = {3'b001, sp, rp};
      default: outv = {3'b010, sp, rp};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_sync = 2'b00; mr_sync = 2'b00;
      ms_lvl = 0; mr_lvl = 0; ms_prev = 0; mr_prev = 0;
      ms_p = 0; mr_p = 0; ms_run = 0; mr_run = 0; mst = 0;
      exp_q.delete();
      exp_q.push_back(outv(0, 1'b0, 1'b0));
    end else begin
      if (ms_lvl && !mr_lvl) mst = 1;
      else if (!ms_lvl && mr_lvl) mst = 0;
      else if (ms_lvl && mr_lvl) mst = 2;
      else if (mst == 2) mst = 0;
      ms_p = ms_lvl && !ms_prev; ms_prev = ms_lvl;
      mr_p = mr_lvl && !mr_prev; mr_prev = mr_lvl;
      if (ms_sync[1] != ms_lvl) begin
        ms_run++;
        if (ms_run == N) begin ms_lvl = ~ms_lvl; ms_run = 0; end
      end else ms_run = 0;
      if (mr_sync[1] != mr_lvl) begin
        mr_run++;
        if (mr_run == N) begin mr_lvl = ~mr_lvl; mr_run = 0; end
      end else mr_run = 0;
      ms_sync = {ms_sync[0], set_btn};
      mr_sync = {mr_sync[0], rst_btn};
      exp_q.push_back(outv(mst, ms_p, mr_p));
    end
  end

  always @(negedge clk) begin
    logic [4:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      assert ({q, notq, invalid, s_pulse, r_pulse} === e)
      else begin
        failures++;
        $error("FAIL model obs=%b exp=%b t=%0t",
               {q, notq, invalid, s_pulse, r_pulse}, e, $time);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (s_pulse === 1'b1) sp_cnt++;
    if (r_pulse === 1'b1) rp_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_q", q, 0);
    chk("rst_notq", notq, 1);
    chk("rst_inv", invalid, 0);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk("idle_q", q, 0);
    chk("idle_notq", notq, 1);
    chk("idle_inv", invalid, 0);
    chk("idle_pulses", sp_cnt + rp_cnt, 0);

    set_btn = 1'b1;
    tick(6);
    chk("lat_q_before", q, 0);
    tick(1);
    chk("lat_q_at7", q, 1);
    chk("lat_notq_at7", notq, 0);
    tick(10);
    chk("set_one_pulse", sp_cnt, 1);

    set_btn = 1'b0;
    tick(10);
    chk("set_release_hold", q, 1);
    set_btn = 1'b1; tick(2);
    set_btn = 1'b0; tick(2);
    set_btn = 1'b1; tick(2);
    set_btn = 1'b0; tick(12);
    chk("bounce_no_pulse", sp_cnt, 1);
    chk("bounce_q", q, 1);

    rst_btn = 1'b1;
    tick(12);
    chk("rst_one_pulse", rp_cnt, 1);
    chk("rst_q", q, 0);
    chk("rst_notq", notq, 1);
    rst_btn = 1'b0;
    tick(10);
    chk("rst_hold_q", q, 0);
    chk("rst_hold_notq", notq, 1);

    set_btn = 1'b1;
    rst_btn = 1'b1;
    tick(10);
    chk("conf_inv", invalid, 1);
    chk("conf_q", q, 0);
    chk("conf_notq", notq, 0);
    rst_btn = 1'b0;
    tick(10);
    chk("conf_to_set_q", q, 1);
    chk("conf_to_set_inv", invalid, 0);
    rst_btn = 1'b1;
    tick(10);
    chk("conf2_inv", invalid, 1);
    set_btn = 1'b0;
    rst_btn = 1'b0;
    tick(10);
    chk("conf_to_rst_q", q, 0);
    chk("conf_to_rst_notq", notq, 1);
    chk("conf_to_rst_inv", invalid, 0);

    set_btn = 1'b1; tick(10);
    set_btn = 1'b0; tick(10);
    chk("pre_rst_q", q, 1);
    set_btn = 1'b1;
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_q", q, 0);
    chk("midrst_notq", notq, 1);
    chk("midrst_pulse", s_pulse, 0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("post_rst_q_before", q, 0);
    tick(1);
    chk("post_rst_q_at7", q, 1);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_debounce_ctrl.md
SR_DEBOUNCE_CTRL -- requirements
Module: sr_debounce_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive synchronized cycles an input must differ from its stable level before that level updates; legal range 2..65535.
REQ-002 Parameter CNT_W, default $clog2(DEBOUNCE_CYCLES)+1, debounce counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 set_btn  input  1  raw, asynchronous, possibly bouncing set request.
REQ-006 rst_btn  input  1  raw, asynchronous, possibly bouncing reset request.
REQ-007 s_pulse  output  1  one-cycle pulse on debounced set rising edge.
REQ-008 r_pulse  output  1  one-cycle pulse on debounced reset rising edge.
REQ-009 q  output  1  registered latch state.
REQ-010 notq  output  1  registered complement of q, except in CONFLICT.
REQ-011 invalid  output  1  high while both debounced levels are high.

Function
REQ-012 Each raw input SHALL pass a 2-flop synchronizer before any other use.
REQ-013 Each channel SHALL hold stable level lvl and counter cnt: synced==lvl -> cnt cleared; synced!=lvl -> cnt increments; cnt reaching DEBOUNCE_CYCLES-1 with mismatch -> lvl toggles and cnt clears in that edge.
REQ-014 A bounce (synced returns to lvl) before the count completes SHALL clear cnt with no lvl change.
REQ-015 s_pulse/r_pulse SHALL assert exactly one cycle, the cycle after the respective lvl goes 0->1; falling edges produce no pulse.
REQ-016 FSM states SHALL be Q_RESET (q=0,notq=1), Q_SET (q=1,notq=0), CONFLICT (q=0,notq=0,invalid=1), mirroring a NOR SR latch.
REQ-017 Transitions on debounced levels (s_lvl,r_lvl): 10 -> Q_SET; 01 -> Q_RESET; 11 -> CONFLICT; 00 -> hold current state, except from CONFLICT -> Q_RESET.
REQ-018 From CONFLICT, 10 -> Q_SET and 01 -> Q_RESET.
REQ-019 q/notq/invalid SHALL be registered FSM outputs, updating the cycle after the lvl change (same cycle as s_pulse/r_pulse).
REQ-020 Total latency, raw edge held stable to q change, SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles, +/-1 cycle for raw-edge phase.
REQ-021 Both levels changing in the same cycle SHALL be evaluated as one combined (s_lvl,r_lvl) value per REQ-017; no intermediate state.
REQ-022 Counters SHALL never wrap; cnt is bounded by DEBOUNCE_CYCLES-1.

Reset
REQ-023 rst_n low SHALL immediately force: synchronizers 0, lvl 0, cnt 0, state Q_RESET, q=0, notq=1, s_pulse=0, r_pulse=0, invalid=0.
REQ-024 Reset mid-debounce SHALL discard partial counts; after release a held button needs the full 2+DEBOUNCE_CYCLES+1 again.
REQ-025 Reset deassertion SHALL take effect on the next clk edge; no output glitches during reset.

Structure
REQ-026 Shared package sr_pkg SHALL hold the FSM state typedef (Q_RESET, Q_SET, CONFLICT) and the default DEBOUNCE_CYCLES constant.
REQ-027 Sub-module sr_debounce_chan (synchronizer + counter + lvl + rising-edge pulse) SHALL be instantiated twice; the FSM lives in sr_debounce_ctrl.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset then idle 20 cycles -> q=0, notq=1, invalid=0, no pulses.
REQ-029 set_btn 0->1 held -> s_pulse one cycle and q=1,notq=0 at 7 (+/-1) cycles after edge; held further -> no second pulse.
REQ-030 set_btn toggles 1,0,1,0 every 2 cycles then stays 0 -> no s_pulse, q unchanged.
REQ-031 In Q_SET, rst_btn high held -> r_pulse once, q=0,notq=1; release both -> state held Q_RESET.
REQ-032 Both buttons high held -> invalid=1, q=0, notq=0; release rst_btn only -> Q_SET; repeat releasing both -> Q_RESET.
REQ-033 rst_n pulsed low while set_btn held 3 cycles into debounce -> outputs at reset values immediately; q=1 only after full latency post-release.
